dual_port_ram_reader: RTL

Read-side master for dual_port_ram. It fetches a contiguous multi-word big-integer operand (for example a Paillier modulus or ciphertext limb array) and streams it out on a valid/ready interface with a last marker. It absorbs the RAM's 1-cycle read latency and rd_en-gated rd_data, and applies backpressure without losing or duplicating words. It sits between the operand RAMs and the modular-multiplier datapath.

---
 rtl/dual_port_ram_reader_pkg.sv | 31 +++
 rtl/dual_port_ram_reader_fifo.sv | 77 +++++++
 rtl/dual_port_ram_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_reader_pkg.sv
// -----------------------------------------------------------------------------
// dual_port_ram_reader_pkg
//
// Shared definitions for the dual_port_ram read-side master:
//   state_t        reader FSM states
//   FIFO_DEPTH     depth of the output skid FIFO
//   FIFO_CNT_W     width of the FIFO occupancy count
//   fcnt_t         FIFO occupancy type
//   cnt_w()        width of word counters for a given RAM address width; one
//                  extra bit so a full-depth transfer (2^ADDR_LINE words)
//                  can be represented.
// -----------------------------------------------------------------------------
package dual_port_ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [FIFO_CNT_W-1:0] fcnt_t;

  function automatic int cnt_w(input int addr_line);
    return addr_line + 1;
  endfunction

endpackage

// File: rtl/dual_port_ram_reader_fifo.sv
// -----------------------------------------------------------------------------
// reader_skid_fifo
//
// Two-entry register FIFO holding captured RAM words (data plus last tag)
// until the downstream stream interface accepts them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; flushes pointers and count
//   push       write push_data at the tail
//   push_data  WIDTH-bit entry to store
//   pop        remove the head entry (ignored when empty)
//   head       current head entry (meaningful only when !empty)
//   empty      no entries stored
//   count      number of entries stored (0..FIFO_DEPTH)
//
// Simultaneous push and pop is legal whenever the FIFO is non-empty and keeps
// the count unchanged. A push into a full FIFO without a pop is dropped; the
// reader's issue rule never produces one.
// -----------------------------------------------------------------------------
module reader_skid_fifo
  import dual_port_ram_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output fcnt_t            count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  fcnt_t            r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == fcnt_t'(FIFO_DEPTH));
  assign w_pop  = pop && (r_count != '0);
  // A pop in the same cycle frees the slot being written.
  assign w_push = push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; validity comes from the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/dual_port_ram_reader.sv
// -----------------------------------------------------------------------------
// dual_port_ram_reader
//
// Read-side master for dual_port_ram. Fetches a contiguous block of
// word_cnt words starting at base_addr and streams it out on a valid/ready
// interface, marking the final word with m_last. The RAM's 1-cycle read
// latency is absorbed by a 2-entry skid FIFO; reads are only issued when the
// FIFO is guaranteed room for the returning word, so backpressure never loses
// or duplicates data.
//
// Parameters:
//   RAM_WIDTH  word width (must match the connected RAM)
//   ADDR_LINE  RAM address width; depth is 2^ADDR_LINE
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; abandons any transfer
//   start        one-cycle request, accepted only in IDLE
//   base_addr    first word address, sampled on an accepted start
//   word_cnt     words to read (0..2^ADDR_LINE), sampled on an accepted start
//   busy         transfer in progress (READ/DRAIN)
//   done         one-cycle completion pulse
//   ram_rd_en    RAM read enable
//   ram_rd_addr  RAM read address
//   ram_rd_data  RAM read data, valid one cycle after ram_rd_en
//   m_valid      stream word valid
//   m_ready      downstream accept
//   m_data       stream word
//   m_last       final word of the operand
//
// Build option:
//   READER_REVERSE_EN  when defined, reads run from base_addr+word_cnt-1 down
//                      to base_addr (most-significant word first) and m_last
//                      marks the base_addr word. Timing is identical.
// -----------------------------------------------------------------------------
module dual_port_ram_reader
  import dual_port_ram_reader_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int ADDR_LINE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LINE-1:0] base_addr,
  input  logic [ADDR_LINE:0]   word_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_rd_en,
  output logic [ADDR_LINE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int CW = cnt_w(ADDR_LINE);
  localparam int OW = FIFO_CNT_W + 1;

  typedef logic [CW-1:0]        cnt_t;
  typedef logic [OW-1:0]        occ_t;
  typedef logic [ADDR_LINE-1:0] addr_t;

  state_t r_state;
  state_t w_state_nxt;

  cnt_t   r_cnt;
  cnt_t   r_issued;
  addr_t  r_addr;
  logic   r_inflight;
  logic   r_inflight_last;

  addr_t  w_start_addr;
  addr_t  w_next_addr;
  logic   w_accept;
  logic   w_last_issue;
  logic   w_issue;
  logic   w_pop;
  occ_t   w_occ;
  occ_t   w_lim;

  logic               w_fifo_empty;
  fcnt_t              w_fifo_count;
  logic [RAM_WIDTH:0] w_fifo_head;

`ifdef READER_REVERSE_EN
  // Highest word first; for a full-depth transfer the low bits of word_cnt
  // are zero, which lands on base_addr-1 as required.
  assign w_start_addr = base_addr + word_cnt[ADDR_LINE-1:0] - addr_t'(1);
  assign w_next_addr  = r_addr - addr_t'(1);
`else
  assign w_start_addr = base_addr;
  assign w_next_addr  = r_addr + addr_t'(1);
`endif

  assign w_accept     = (r_state == IDLE) && start;
  assign w_pop        = m_valid && m_ready;
  assign w_last_issue = (r_issued == (r_cnt - cnt_t'(1)));

  // Words already owed to the FIFO (stored plus one in flight from the RAM),
  // net of this cycle's pop, must leave room for the word we are about to
  // request: count + inflight - pop < FIFO_DEPTH.
  assign w_occ   = occ_t'(w_fifo_count) + occ_t'(r_inflight);
  assign w_lim   = occ_t'(FIFO_DEPTH) + occ_t'(w_pop);
  assign w_issue = (r_state == READ) && (w_occ < w_lim);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (word_cnt == '0) ? FINISH : READ;
      end
      READ: begin
        if (w_issue && w_last_issue) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_pop && w_fifo_head[RAM_WIDTH]) w_state_nxt = FINISH;
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_issued        <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue;
      // The last tag rides with the read so it is attached at capture.
      r_inflight_last <= w_issue && w_last_issue;
      if (w_accept) begin
        r_cnt    <= word_cnt;
        r_issued <= '0;
        r_addr   <= w_start_addr;
      end else if (w_issue) begin
        r_issued <= r_issued + cnt_t'(1);
        r_addr   <= w_next_addr;
      end
    end
  end

  // ---- capture stage: RAM data returns one cycle after ram_rd_en ----
  reader_skid_fifo #(
    .WIDTH (RAM_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data ({r_inflight_last, ram_rd_data}),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // ---- output stage ----
  assign busy        = (r_state == READ) || (r_state == DRAIN);
  assign done        = (r_state == FINISH);
  assign ram_rd_en   = w_issue;
  assign ram_rd_addr = r_addr;
  assign m_valid     = !w_fifo_empty;
  // Gate with valid so the stream reads zero when idle or after reset.
  assign m_data      = w_fifo_empty ? '0 : w_fifo_head[RAM_WIDTH-1:0];
  assign m_last      = !w_fifo_empty && w_fifo_head[RAM_WIDTH];

endmodule
